// File: rtl/seg_display_driver.sv
// Four-digit multiplexed common-anode seven-segment driver for a 16-bit word.
// The word is sampled only at frame boundaries so a scan never mixes two values.
module seg_display_driver #(
    parameter int REFRESH_DIV   = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        freeze,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        changed
);

    localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [TW-1:0] tick;
    logic [1:0]    digit;
    logic [15:0]   shadow;
    logic          frz_q;

    logic          tick_last;
    logic          frame_end;
    logic [15:0]   shifted;
    logic [3:0]    nibble;
    logic          blank;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Shifting the shadow down to the current digit gives both the nibble and
    // the "everything from here upward is zero" test used for blanking.
    always_comb begin
        tick_last = (tick == TW'(REFRESH_DIV - 1));
        frame_end = tick_last && (digit == 2'd3);
        shifted   = shadow >> {digit, 2'b00};
        nibble    = shifted[3:0];
        blank     = BLANK_LEADING && (digit != 2'd0) && (shifted == 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick    <= '0;
            digit   <= 2'd0;
            shadow  <= 16'h0000;
            frz_q   <= 1'b0;
            changed <= 1'b0;
            an      <= 4'b1111;
            seg     <= 7'b1111111;
            dp      <= 1'b1;
        end else begin
            if (tick_last) begin
                tick  <= '0;
                digit <= digit + 2'd1;
            end else begin
                tick  <= tick + TW'(1);
            end

            changed <= 1'b0;
            if (frame_end) begin
                frz_q <= freeze;
                if (!freeze) begin
                    shadow  <= value;
                    changed <= (value != shadow);
                end
            end

            // Outputs reflect the digit/shadow of the previous cycle.
            an  <= blank ? 4'b1111 : ~(4'b0001 << digit);
            seg <= blank ? 7'b1111111 : hex_to_seg(nibble);
            dp  <= !((digit == 2'd0) && frz_q);
        end
    end

endmodule

// File: tb/tb_seg_display_driver.sv
// Randomised bench for seg_display_driver: three instances (blanking on/off,
// and a one-cycle refresh) checked every cycle against a frame-arithmetic model.
module tb_seg_display_driver;

    localparam int N_INST = 3;
    localparam int R_OF [N_INST] = '{4, 4, 1};
    localparam bit B_OF [N_INST] = '{1'b1, 1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        freeze;

    logic [3:0]  an_w  [N_INST];
    logic [6:0]  seg_w [N_INST];
    logic        dp_w  [N_INST];
    logic        ch_w  [N_INST];

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int          n_m    [N_INST];
    logic [15:0] sh_m   [N_INST];
    logic        fz_m   [N_INST];
    logic [3:0]  exp_an [N_INST];
    logic [6:0]  exp_seg[N_INST];
    logic        exp_dp [N_INST];
    logic        exp_ch [N_INST];
    bit          model_valid = 1'b0;

    always #5 clk = ~clk;

    seg_display_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) u_blank (
        .clk(clk), .reset(reset), .value(value), .freeze(freeze),
        .an(an_w[0]), .seg(seg_w[0]), .dp(dp_w[0]), .changed(ch_w[0]));

    seg_display_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) u_full (
        .clk(clk), .reset(reset), .value(value), .freeze(freeze),
        .an(an_w[1]), .seg(seg_w[1]), .dp(dp_w[1]), .changed(ch_w[1]));

    seg_display_driver #(.REFRESH_DIV(1), .BLANK_LEADING(1'b1)) u_fast (
        .clk(clk), .reset(reset), .value(value), .freeze(freeze),
        .an(an_w[2]), .seg(seg_w[2]), .dp(dp_w[2]), .changed(ch_w[2]));

    task automatic check_output(input string name, input int inst,
                                input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            fails++;
            if (fails <= 60)
                $display("[TB] FAIL %s inst%0d actual=%h expected=%h t=%0t",
                         name, inst, act, exp, $time);
        end
    endtask

    // Display content for a given digit position, derived from the word alone.
    function automatic logic [11:0] display_of(input int d, input logic [15:0] sh,
                                               input logic fz, input bit blank_en);
        logic [15:0] upper;
        logic [3:0]  a;
        logic [6:0]  s;
        logic        p;
        upper = sh >> (4 * d);
        if (blank_en && d > 0 && upper == 16'h0000) begin
            a = 4'b1111;
            s = 7'b1111111;
        end else begin
            a = ~(4'b0001 << d);
            s = seg_tab[upper[3:0]];
        end
        p = (d == 0 && fz) ? 1'b0 : 1'b1;
        return {a, s, p};
    endfunction

    // Model: n counts edges since reset; edge n shows digit ((n-1)/R)%4 of the
    // word held before that edge, and every 4R-th edge is a sampling point.
    always @(posedge clk) begin
        for (int i = 0; i < N_INST; i++) begin
            if (reset) begin
                n_m[i]     = 0;
                sh_m[i]    = 16'h0000;
                fz_m[i]    = 1'b0;
                exp_an[i]  = 4'b1111;
                exp_seg[i] = 7'b1111111;
                exp_dp[i]  = 1'b1;
                exp_ch[i]  = 1'b0;
            end else begin
                logic [11:0] disp;
                n_m[i]++;
                disp = display_of(((n_m[i] - 1) / R_OF[i]) % 4, sh_m[i], fz_m[i], B_OF[i]);
                {exp_an[i], exp_seg[i], exp_dp[i]} = disp;
                exp_ch[i] = 1'b0;
                if (n_m[i] % (4 * R_OF[i]) == 0) begin
                    if (!freeze) begin
                        exp_ch[i] = (value != sh_m[i]);
                        sh_m[i]   = value;
                    end
                    fz_m[i] = freeze;
                end
            end
        end
        if (reset) model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            for (int i = 0; i < N_INST; i++) begin
                check_output("an",      i, 16'(an_w[i]),  16'(exp_an[i]));
                check_output("seg",     i, 16'(seg_w[i]), 16'(exp_seg[i]));
                check_output("dp",      i, 16'(dp_w[i]),  16'(exp_dp[i]));
                check_output("changed", i, 16'(ch_w[i]),  16'(exp_ch[i]));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [15:0] v, input logic f, input int cycles);
        value  = v;
        freeze = f;
        step(cycles);
    endtask

    initial begin
        reset  = 1'b1;
        value  = 16'h1234;
        freeze = 1'b0;
        step(2);
        check_output("lit_reset_an",  0, 16'(an_w[0]),  16'h000f);
        check_output("lit_reset_seg", 0, 16'(seg_w[0]), 16'h007f);
        check_output("lit_reset_ch",  0, 16'(ch_w[0]),  16'h0000);
        reset = 1'b0;

        step(1);
        check_output("lit_first_an",  0, 16'(an_w[0]),  16'h000e);
        check_output("lit_first_seg", 0, 16'(seg_w[0]), 16'h0040);
        step(3);
        check_output("lit_fast_changed", 2, 16'(ch_w[2]), 16'h0001);
        check_output("lit_slow_nochg",   0, 16'(ch_w[0]), 16'h0000);
        step(1);
        check_output("lit_blank_d1_an", 0, 16'(an_w[0]),  16'h000f);
        check_output("lit_full_d1_an",  1, 16'(an_w[1]),  16'h000d);
        check_output("lit_full_d1_seg", 1, 16'(seg_w[1]), 16'h0040);
        step(11);
        check_output("lit_changed_16", 0, 16'(ch_w[0]), 16'h0001);
        step(1);
        check_output("lit_changed_17", 0, 16'(ch_w[0]),  16'h0000);
        check_output("lit_f2_d0_an",   0, 16'(an_w[0]),  16'h000e);
        check_output("lit_f2_d0_seg",  0, 16'(seg_w[0]), 16'h0019);
        step(4);
        check_output("lit_f2_d1_an",   0, 16'(an_w[0]),  16'h000d);
        check_output("lit_f2_d1_seg",  0, 16'(seg_w[0]), 16'h0030);
        step(4);
        check_output("lit_f2_d2_seg",  0, 16'(seg_w[0]), 16'h0024);
        step(4);
        check_output("lit_f2_d3_an",   0, 16'(an_w[0]),  16'h0007);
        check_output("lit_f2_d3_seg",  0, 16'(seg_w[0]), 16'h0079);

        apply_stimulus(16'h00A0, 1'b0, 40);
        apply_stimulus(16'hBEEF, 1'b1, 40);
        apply_stimulus(16'hBEEF, 1'b0, 40);
        apply_stimulus(16'hBEEF, 1'b0, 48);

        for (int k = 0; k < 40; k++)
            apply_stimulus((k % 2 == 0) ? 16'h1111 : 16'h2222, 1'b0, 1);

        // Reset pulse landing in the digit-2 slot of the slow instances.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        value = 16'h5A00;
        step(9);
        reset = 1'b1;
        step(1);
        check_output("lit_midreset_an",  0, 16'(an_w[0]),  16'h000f);
        check_output("lit_midreset_seg", 0, 16'(seg_w[0]), 16'h007f);
        check_output("lit_midreset_ch",  0, 16'(ch_w[0]),  16'h0000);
        reset = 1'b0;
        step(20);

        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                logic [15:0] mask;
                case ($urandom_range(0, 4))
                    0:       mask = 16'hffff;
                    1:       mask = 16'h0fff;
                    2:       mask = 16'h00ff;
                    3:       mask = 16'h000f;
                    default: mask = 16'h0000;
                endcase
                value = 16'($urandom) & mask;
            end
            if ($urandom_range(0, 39) == 0) freeze = ~freeze;
            reset = ($urandom_range(0, 149) == 0);
            step(1);
        end
        reset = 1'b0;
        step(2);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
